// File: rtl/occ_rom_arbiter_pkg.sv
// Shared definitions for the rom_Occ arbiter: FSM state codes, base-select
// codes and the byte-lane layout of an Occ word.
package occ_rom_arbiter_pkg;

  typedef enum logic [1:0] {
    OCC_IDLE = 2'd0,
    OCC_READ = 2'd1,
    OCC_WAIT = 2'd2,
    OCC_CAPT = 2'd3
  } occ_state_t;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam int CNT_W      = 8;
  localparam int LANE_A_LSB = 0;
  localparam int LANE_C_LSB = 8;
  localparam int LANE_G_LSB = 16;
  localparam int LANE_T_LSB = 24;

  // Pick the 8-bit count for one base out of a packed Occ word.
  function automatic logic [CNT_W-1:0] occ_lane(input logic [31:0] word,
                                                input logic [1:0]  sel);
    logic [CNT_W-1:0] cnt;
    case (sel)
      BASE_A:  cnt = word[LANE_A_LSB +: CNT_W];
      BASE_C:  cnt = word[LANE_C_LSB +: CNT_W];
      BASE_G:  cnt = word[LANE_G_LSB +: CNT_W];
      BASE_T:  cnt = word[LANE_T_LSB +: CNT_W];
      default: cnt = '0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/occ_rom_arbiter_arb2.sv
// Combinational two-way round-robin picker: when both ports request, the
// port named by rr_ptr wins; otherwise the single requester wins.
module occ_rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_ptr,
  output logic o_gnt_id,
  output logic o_any
);

  always_comb begin
    o_any    = i_req0 | i_req1;
    o_gnt_id = 1'b0;
    if (i_req0 && i_req1) begin
      o_gnt_id = i_rr_ptr;
    end else begin
      o_gnt_id = i_req1;
    end
  end

endmodule

// File: rtl/occ_rom_arbiter.sv
// Shares the single rom_Occ read port between the l-count and k-1 count
// fetch stages; one outstanding read, round-robin, fixed ROM latency.
module occ_rom_arbiter
  import occ_rom_arbiter_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter int AW      = 8,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [1:0]    sel0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [1:0]    sel1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [7:0]    rcount,
  output logic          busy,
  output logic          ce_rom,
  output logic [AW-1:0] addr_rom,
  input  logic [DW-1:0] data_rom
);

  localparam logic [2:0] LAT_INIT = 3'(ROM_LAT - 1);

  occ_state_t    r_state, w_state;
  logic          r_rr_ptr, w_rr_ptr;
  logic [2:0]    r_lat_cnt, w_lat_cnt;
  logic          r_owner, w_owner;
  logic [1:0]    r_sel, w_sel;
  logic          r_gnt0, w_gnt0;
  logic          r_gnt1, w_gnt1;
  logic          r_rvalid0, w_rvalid0;
  logic          r_rvalid1, w_rvalid1;
  logic [DW-1:0] r_rdata, w_rdata;
  logic [7:0]    r_rcount, w_rcount;
  logic          r_busy, w_busy;
  logic          r_ce, w_ce;
  logic [AW-1:0] r_addr_rom, w_addr_rom;
  logic          w_capture;
  logic          w_gnt_id;
  logic          w_any;

  occ_rr_arb2 u_arb (
    .i_req0   (req0),
    .i_req1   (req1),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_any)
  );

  // Next-state and next-output logic; every output is a register loaded here.
  always_comb begin
    w_state    = r_state;
    w_rr_ptr   = r_rr_ptr;
    w_lat_cnt  = r_lat_cnt;
    w_owner    = r_owner;
    w_sel      = r_sel;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_rvalid0  = 1'b0;
    w_rvalid1  = 1'b0;
    w_rdata    = r_rdata;
    w_rcount   = r_rcount;
    w_ce       = r_ce;
    w_addr_rom = r_addr_rom;
    w_capture  = 1'b0;

    case (r_state)
      OCC_IDLE: begin
        if (w_any) begin
          w_owner    = w_gnt_id;
          w_sel      = w_gnt_id ? sel1 : sel0;
          w_addr_rom = w_gnt_id ? addr1 : addr0;
          w_gnt0     = ~w_gnt_id;
          w_gnt1     = w_gnt_id;
          w_rr_ptr   = ~w_gnt_id;
          w_ce       = 1'b1;
          w_lat_cnt  = LAT_INIT;
          w_state    = OCC_READ;
        end
      end
      OCC_READ: begin
        if (ROM_LAT == 1) begin
          w_capture = 1'b1;
        end else begin
          w_state = OCC_WAIT;
        end
      end
      OCC_WAIT: begin
        if (r_lat_cnt <= 3'd1) begin
          w_capture = 1'b1;
        end else begin
          w_lat_cnt = r_lat_cnt - 3'd1;
        end
      end
      OCC_CAPT: begin
        w_state = OCC_IDLE;
      end
      default: begin
        w_state = OCC_IDLE;
      end
    endcase

    // Data is sampled on the last cycle the ROM sees ce, so it is visible during CAPT.
    if (w_capture) begin
      w_rdata    = data_rom;
      w_rcount   = occ_lane(32'(data_rom), r_sel);
      w_ce       = 1'b0;
      w_addr_rom = '0;
      w_rvalid0  = ~r_owner;
      w_rvalid1  = r_owner;
      w_state    = OCC_CAPT;
    end

    w_busy = (w_state != OCC_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= OCC_IDLE;
      r_rr_ptr   <= 1'b0;
      r_lat_cnt  <= '0;
      r_owner    <= 1'b0;
      r_sel      <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata    <= '0;
      r_rcount   <= '0;
      r_busy     <= 1'b0;
      r_ce       <= 1'b0;
      r_addr_rom <= '0;
    end else begin
      r_state    <= w_state;
      r_rr_ptr   <= w_rr_ptr;
      r_lat_cnt  <= w_lat_cnt;
      r_owner    <= w_owner;
      r_sel      <= w_sel;
      r_gnt0     <= w_gnt0;
      r_gnt1     <= w_gnt1;
      r_rvalid0  <= w_rvalid0;
      r_rvalid1  <= w_rvalid1;
      r_rdata    <= w_rdata;
      r_rcount   <= w_rcount;
      r_busy     <= w_busy;
      r_ce       <= w_ce;
      r_addr_rom <= w_addr_rom;
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata    = r_rdata;
  assign rcount   = r_rcount;
  assign busy     = r_busy;
  assign ce_rom   = r_ce;
  assign addr_rom = r_addr_rom;

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Bench for occ_rom_arbiter: one instance with ROM_LAT=1 (A), one with ROM_LAT=3 (B),
// each backed by a ROM model that only returns real data on the ROM_LAT-th ce cycle.
module tb_occ_rom_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    bit          port;
    logic [31:0] data;
    logic [7:0]  cnt;
  } sb_t;

  typedef struct {
    bit          port;
    logic [7:0]  addr;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [7:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic ra0 = 0, ra1 = 0, rb0 = 0, rb1 = 0;
  logic [7:0] aa0 = 0, aa1 = 0, ab0 = 0, ab1 = 0;
  logic [1:0] sa0 = 0, sa1 = 0, sb0 = 0, sb1 = 0;
  logic ga0, ga1, va0, va1, busyA, ceA;
  logic gb0, gb1, vb0, vb1, busyB, ceB;
  logic [31:0] rdA, rdB, drA, drB;
  logic [7:0]  rcA, rcB, arA, arB;

  logic [31:0] rom [256];
  logic [3:0]  cecA = 0, cecB = 0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  sb_t sbqA[$];
  sb_t sbqB[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  occ_rom_arbiter #(.ROM_LAT(LAT_A), .AW(8), .DW(32)) dutA (
    .clk(clk), .rst_n(rst_n),
    .req0(ra0), .addr0(aa0), .sel0(sa0), .gnt0(ga0), .rvalid0(va0),
    .req1(ra1), .addr1(aa1), .sel1(sa1), .gnt1(ga1), .rvalid1(va1),
    .rdata(rdA), .rcount(rcA), .busy(busyA),
    .ce_rom(ceA), .addr_rom(arA), .data_rom(drA)
  );

  occ_rom_arbiter #(.ROM_LAT(LAT_B), .AW(8), .DW(32)) dutB (
    .clk(clk), .rst_n(rst_n),
    .req0(rb0), .addr0(ab0), .sel0(sb0), .gnt0(gb0), .rvalid0(vb0),
    .req1(rb1), .addr1(ab1), .sel1(sb1), .gnt1(gb1), .rvalid1(vb1),
    .rdata(rdB), .rcount(rcB), .busy(busyB),
    .ce_rom(ceB), .addr_rom(arB), .data_rom(drB)
  );

  // ROM model: data is only valid on the ROM_LAT-th consecutive ce cycle.
  always_ff @(posedge clk) begin
    cecA <= ceA ? cecA + 4'd1 : 4'd0;
    cecB <= ceB ? cecB + 4'd1 : 4'd0;
  end
  assign drA = (ceA && cecA == 4'(LAT_A - 1)) ? rom[arA] : 32'hDEADBEEF;
  assign drB = (ceB && cecB == 4'(LAT_B - 1)) ? rom[arB] : 32'hDEADBEEF;

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] s);
    return w[8*s +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon();
    sb_t e;
    if (va0 || va1) begin
      chk("A_single_rvalid", {31'd0, va0 & va1}, 32'd0);
      if (sbqA.size() == 0) begin
        chk("A_spurious_rvalid", {30'd0, va1, va0}, 32'd0);
      end else begin
        e = sbqA.pop_front();
        chk("A_rvalid_port", {31'd0, va1}, {31'd0, e.port});
        chk("A_rdata", rdA, e.data);
        chk("A_rcount", {24'd0, rcA}, {24'd0, e.cnt});
      end
    end
    if (vb0 || vb1) begin
      chk("B_single_rvalid", {31'd0, vb0 & vb1}, 32'd0);
      if (sbqB.size() == 0) begin
        chk("B_spurious_rvalid", {30'd0, vb1, vb0}, 32'd0);
      end else begin
        e = sbqB.pop_front();
        chk("B_rvalid_port", {31'd0, vb1}, {31'd0, e.port});
        chk("B_rdata", rdB, e.data);
        chk("B_rcount", {24'd0, rcB}, {24'd0, e.cnt});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic push_a(input bit p, input logic [7:0] a, input logic [1:0] s);
    sb_t e;
    e.port = p;
    e.data = rom[a];
    e.cnt  = lane(rom[a], s);
    sbqA.push_back(e);
  endtask

  task automatic push_b(input bit p, input logic [7:0] a, input logic [1:0] s);
    sb_t e;
    e.port = p;
    e.data = rom[a];
    e.cnt  = lane(rom[a], s);
    sbqB.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sbqA.size() != 0 || sbqB.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(sbqA.size() + sbqB.size()), 32'd0);
  endtask

  task automatic do_reset();
    ra0 = 0; ra1 = 0; rb0 = 0; rb1 = 0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    sbqA.delete();
    sbqB.delete();
    step();
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_A_ctl"}, {26'd0, ga0, ga1, va0, va1, busyA, ceA}, 32'd0);
    chk({tag, "_A_addr_rom"}, {24'd0, arA}, 32'd0);
    chk({tag, "_A_rdata"}, rdA, 32'd0);
    chk({tag, "_A_rcount"}, {24'd0, rcA}, 32'd0);
  endtask

  task automatic chk_zero_b(input string tag);
    chk({tag, "_B_ctl"}, {26'd0, gb0, gb1, vb0, vb1, busyB, ceB}, 32'd0);
    chk({tag, "_B_addr_rom"}, {24'd0, arB}, 32'd0);
    chk({tag, "_B_rdata"}, rdB, 32'd0);
    chk({tag, "_B_rcount"}, {24'd0, rcB}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int last;
    bit got;
    bit p;

    for (int i = 0; i < 256; i++) begin
      rom[i] = {8'(i) ^ 8'hA5, 8'(i) + 8'h11, ~8'(i), 8'(i)};
    end
    rom[8'h10] = 32'h44332211;
    rom[8'hFF] = 32'hAB000000;
    rom[8'h00] = 32'h01020304;
    rom[8'h80] = 32'hF0E0D0C0;
    rom[8'h33] = 32'h7F80FF00;
    rom[8'hFE] = 32'h11223344;

    vecs[0] = '{1'b0, 8'h00, 2'd0, 32'h01020304, 8'h04};
    vecs[1] = '{1'b1, 8'h00, 2'd3, 32'h01020304, 8'h01};
    vecs[2] = '{1'b0, 8'h80, 2'd2, 32'hF0E0D0C0, 8'hE0};
    vecs[3] = '{1'b1, 8'h33, 2'd1, 32'h7F80FF00, 8'hFF};
    vecs[4] = '{1'b0, 8'hFE, 2'd3, 32'h11223344, 8'h11};
    vecs[5] = '{1'b1, 8'hFE, 2'd2, 32'h11223344, 8'h22};
    vecs[6] = '{1'b1, 8'h33, 2'd2, 32'h7F80FF00, 8'h80};
    vecs[7] = '{1'b0, 8'h10, 2'd1, 32'h44332211, 8'h22};

    // Reset state
    step();
    chk_zero_a("reset");
    chk_zero_b("reset");
    rst_n = 1'b1;
    step();

    // Single request, ROM_LAT=1
    ra0 = 1; aa0 = 8'h10; sa0 = 2'd1;
    push_a(1'b0, 8'h10, 2'd1);
    step();
    chk("single_gnt0", {31'd0, ga0}, 32'd1);
    chk("single_gnt1", {31'd0, ga1}, 32'd0);
    chk("single_ce", {31'd0, ceA}, 32'd1);
    chk("single_addr_rom", {24'd0, arA}, 32'h10);
    chk("single_busy", {31'd0, busyA}, 32'd1);
    chk("single_no_early_rvalid", {31'd0, va0}, 32'd0);
    ra0 = 0; sa0 = 2'd3;
    step();
    chk("single_rvalid0", {31'd0, va0}, 32'd1);
    chk("single_rvalid1", {31'd0, va1}, 32'd0);
    chk("single_ce_off", {31'd0, ceA}, 32'd0);
    chk("single_rcount", {24'd0, rcA}, 32'h22);
    step();
    chk("single_idle_busy", {31'd0, busyA}, 32'd0);
    chk("single_rdata_hold", rdA, 32'h44332211);
    chk("single_queue_empty", 32'(sbqA.size()), 32'd0);

    // Simultaneous requests after reset: port 0 first, then port 1
    do_reset();
    ra0 = 1; aa0 = 8'h05; sa0 = 2'd0;
    ra1 = 1; aa1 = 8'h07; sa1 = 2'd2;
    push_a(1'b0, 8'h05, 2'd0);
    push_a(1'b1, 8'h07, 2'd2);
    step();
    chk("sim_first_gnt0", {31'd0, ga0}, 32'd1);
    chk("sim_first_gnt1", {31'd0, ga1}, 32'd0);
    ra0 = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      if (ga1) begin
        got = 1;
        chk("sim_second_gap", 32'(k), 32'd2);
      end
    end
    chk("sim_second_gnt1", {31'd0, got}, 32'd1);
    ra1 = 0;
    drain(10);
    step();

    // Fairness under continuous requests; also confirms rr_ptr returned to 0
    for (int i = 0; i < 6; i++) begin
      p = i[0];
      push_a(p, p ? 8'h42 : 8'h21, p ? 2'd0 : 2'd3);
    end
    ra0 = 1; aa0 = 8'h21; sa0 = 2'd3;
    ra1 = 1; aa1 = 8'h42; sa1 = 2'd0;
    g = 0;
    last = 0;
    for (int k = 0; k < 60 && g < 6; k++) begin
      step();
      if (ga0 || ga1) begin
        chk("fair_one_gnt", {31'd0, ga0 & ga1}, 32'd0);
        chk("fair_order", {31'd0, ga1}, 32'(g % 2));
        if (g > 0) chk("fair_period", 32'(cyc - last), 32'(LAT_A + 2));
        last = cyc;
        g++;
        if (g == 6) begin
          ra0 = 0; ra1 = 0;
        end
      end
    end
    chk("fair_grants", 32'(g), 32'd6);
    drain(10);
    step();

    // Table-driven single requests; sel is scrambled after the grant
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].port) begin
        ra1 = 1; aa1 = vecs[v].addr; sa1 = vecs[v].sel;
      end else begin
        ra0 = 1; aa0 = vecs[v].addr; sa0 = vecs[v].sel;
      end
      sbqA.push_back('{vecs[v].port, vecs[v].data, vecs[v].cnt});
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
        step();
        if (ga0 || ga1) begin
          got = 1;
          chk("vec_gnt_port", {31'd0, ga1}, {31'd0, vecs[v].port});
        end
      end
      chk("vec_gnt_seen", {31'd0, got}, 32'd1);
      ra0 = 0; ra1 = 0;
      sa0 = ~vecs[v].sel; sa1 = ~vecs[v].sel;
      aa0 = 8'hEE; aa1 = 8'hEE;
      drain(10);
      step();
    end

    // Latency with ROM_LAT=3
    rb1 = 1; ab1 = 8'hFF; sb1 = 2'd3;
    push_b(1'b1, 8'hFF, 2'd3);
    step();
    chk("lat_gnt1", {31'd0, gb1}, 32'd1);
    chk("lat_ce_1", {31'd0, ceB}, 32'd1);
    chk("lat_addr_rom", {24'd0, arB}, 32'hFF);
    rb1 = 0;
    step();
    chk("lat_ce_2", {31'd0, ceB}, 32'd1);
    chk("lat_no_rvalid_2", {31'd0, vb1}, 32'd0);
    step();
    chk("lat_ce_3", {31'd0, ceB}, 32'd1);
    chk("lat_no_rvalid_3", {31'd0, vb1}, 32'd0);
    step();
    chk("lat_ce_off", {31'd0, ceB}, 32'd0);
    chk("lat_rvalid1", {31'd0, vb1}, 32'd1);
    chk("lat_rcount", {24'd0, rcB}, 32'hAB);
    step();
    chk("lat_queue_empty", 32'(sbqB.size()), 32'd0);

    // Reset in the middle of WAIT aborts without rvalid
    rb0 = 1; ab0 = 8'h10; sb0 = 2'd0;
    step();
    chk("rstw_gnt0", {31'd0, gb0}, 32'd1);
    rb0 = 0;
    step();
    chk("rstw_in_wait_ce", {31'd0, ceB}, 32'd1);
    rst_n = 1'b0;
    step();
    chk_zero_b("rstw");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("rstw_idle_busy", {31'd0, busyB}, 32'd0);
    rb0 = 1; ab0 = 8'h80; sb0 = 2'd1;
    push_b(1'b0, 8'h80, 2'd1);
    step();
    chk("rstw_new_gnt0", {31'd0, gb0}, 32'd1);
    rb0 = 0;
    drain(10);
    step();

    // Request arriving while busy: served right after the one IDLE cycle
    ra0 = 1; aa0 = 8'h05; sa0 = 2'd0;
    push_a(1'b0, 8'h05, 2'd0);
    step();
    chk("busyreq_gnt0", {31'd0, ga0}, 32'd1);
    ra0 = 0;
    ra1 = 1; aa1 = 8'h07; sa1 = 2'd1;
    push_a(1'b1, 8'h07, 2'd1);
    step();
    chk("busyreq_capt_rvalid0", {31'd0, va0}, 32'd1);
    chk("busyreq_capt_busy", {31'd0, busyA}, 32'd1);
    chk("busyreq_capt_no_gnt1", {31'd0, ga1}, 32'd0);
    step();
    chk("busyreq_idle_busy", {31'd0, busyA}, 32'd0);
    chk("busyreq_idle_no_gnt1", {31'd0, ga1}, 32'd0);
    step();
    chk("busyreq_gnt1", {31'd0, ga1}, 32'd1);
    chk("busyreq_busy_again", {31'd0, busyA}, 32'd1);
    ra1 = 0;
    drain(10);
    step();
    chk("final_busyA", {31'd0, busyA}, 32'd0);
    chk("final_busyB", {31'd0, busyB}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/occ_rom_arbiter.md
Name: occ_rom_arbiter

Overview:
- Shares the single rom_Occ read port between two fetch stages:
  - port 0: the l-count fetch stage.
  - port 1: the k-1 count fetch stage.
- Round-robin arbitration; one outstanding read at a time; fixed, parameterised ROM read latency.
- Returns the full 32-bit Occ word and the 8-bit count for the requested base (A/C/G/T byte lane) to the granted requester with a one-cycle valid pulse.
- Sits between the get_data stages and rom_Occ. Replaces direct ce/addr driving by those stages.

Parameters:
- ROM_LAT, 1, rom_Occ read latency in cycles from first ce/addr cycle to data_rom valid; legal 1..4.
- AW, 8, rom_Occ address width.
- DW, 32, rom_Occ word width; four 8-bit counts, A=[7:0], C=[15:8], G=[23:16], T=[31:24].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0  in  1  port 0 read request; held until gnt0.
- addr0  in  AW  port 0 address; valid while req0.
- sel0  in  2  port 0 base select: 0=A, 1=C, 2=G, 3=T.
- gnt0  out  1  one-cycle grant pulse for port 0.
- rvalid0  out  1  one-cycle pulse: rdata/rcount valid for port 0.
- req1, addr1, sel1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  out  DW  latched Occ word, shared by both ports.
- rcount  out  8  byte lane of rdata chosen by the latched sel.
- busy  out  1  high in any state except IDLE.
- ce_rom  out  1  rom_Occ chip enable.
- addr_rom  out  AW  rom_Occ address.
- data_rom  in  DW  rom_Occ read data.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0 (port 0 has priority), lat_cnt=0.
  - All outputs 0: gnt*, rvalid*, ce_rom, addr_rom, rdata, rcount, busy.
  - Reset mid-transaction aborts it. No rvalid is issued for the aborted read.
- State IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant port rr_ptr.
  - On grant:
    - latch owner id, addr, sel;
    - pulse gnt<owner> for one cycle;
    - set rr_ptr to the other port;
    - go to READ.
- State READ:
  - ce_rom=1, addr_rom=latched addr, lat_cnt=ROM_LAT-1.
  - If ROM_LAT==1, go to CAPT; otherwise go to WAIT.
- State WAIT:
  - ce_rom and addr_rom held; lat_cnt decrements.
  - Go to CAPT when lat_cnt reaches 1.
- State CAPT:
  - rdata<=data_rom; rcount<=byte lane sel; ce_rom<=0; addr_rom<=0.
  - Pulse rvalid<owner> for one cycle; go to IDLE.
- Timing with ROM_LAT=1:
  - req seen at edge T; gnt and ce high during T+1; rvalid high during T+2.
  - General latency req->rvalid = ROM_LAT+1 cycles.
  - Throughput: one read per ROM_LAT+2 cycles.
- Requester rules:
  - Deassert req the cycle after gnt.
  - A req still high in the cycle after its gnt counts as a new request.
  - req arriving while busy waits; it is served in priority order on return to IDLE.
- rdata and rcount hold their value until the next CAPT.
- Only the owner's rvalid pulses; the other port ignores rdata.
- addr is used unmodified (the k-1 subtraction is the requester's job). addr wraps naturally within AW bits.
- sel is latched at grant; changes to sel after grant have no effect.

Decomposition:
- Shared include (config.v) holds:
  - state encodings OCC_IDLE/OCC_READ/OCC_WAIT/OCC_CAPT;
  - base-select codes BASE_A..BASE_T;
  - byte-lane positions.
- One sub-module, occ_rr_arb2: combinational two-way round-robin picker (req0, req1, rr_ptr -> grant id, any). The FSM, latency counter and datapath stay in the top.

Test Plan:
- Single request: port 0 req, addr0=0x10, sel0=1, ROM[0x10]=0x44332211, ROM_LAT=1 -> gnt0 at T+1, ce_rom=1 with addr_rom=0x10 at T+1, rvalid0 at T+2, rdata=0x44332211, rcount=0x22, rvalid1 stays 0.
- Simultaneous requests after reset, addr0=0x05, addr1=0x07 -> port 0 served first, then port 1. Each rvalid returns the correct word; rr_ptr ends at 0.
- Fairness: both ports request continuously for 6 grants -> grants alternate 0,1,0,1,0,1; no port is starved.
- Latency: ROM_LAT=3, port 1 addr1=0xFF, sel1=3, ROM[0xFF]=0xAB000000 -> ce_rom high 3 cycles, rvalid1 at T+4, rcount=0xAB.
- Reset mid-WAIT: ROM_LAT=3, rst_n low during WAIT -> next cycle all outputs 0, state IDLE, no rvalid; a new request afterwards completes normally.
- Request during busy: req1 arrives while port 0 is in READ -> gnt1 exactly one cycle after port 0's CAPT cycle; busy stays 0 for that one IDLE cycle only.
